// File: rtl/press_pkg.sv
// Shared encodings for the press decoder: FSM state codes and event codes reported on LAST.
package press_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT1 = 2'b01,
        WAIT2 = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_SINGLE = 2'd1,
        EV_DOUBLE = 2'd2,
        EV_TRIPLE = 2'd3
    } ev_t;

endpackage

// File: rtl/press_window_timer.sv
// Gesture window down-counter: load sets it to WINDOW, expire flags the terminal count on a decrement.
module press_window_timer #(
    parameter int WINDOW = 8,
    parameter int TW     = $clog2(WINDOW + 1)
) (
    input  logic CLK,
    input  logic ACLR_L,
    input  logic load,
    input  logic dec,
    output logic expire
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = TW'(WINDOW);
        else if (dec)
            cnt_d = cnt_q - TW'(1);
    end

    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // The owner leaves the counting state on expire, so the counter never wraps below 0.
    assign expire = dec && (cnt_q == TW'(1));

endmodule

// File: rtl/press_decoder.sv
// Groups debounced press pulses into single/double (and, with PRESS_TRIPLE_EN, triple) events.
// Optional build macro: PRESS_TRIPLE_EN enables the WAIT2 state and the TRIPLE event.
//
// state | meaning
// IDLE  | no gesture open
// WAIT1 | one press seen, window running
// WAIT2 | two presses seen, window running (PRESS_TRIPLE_EN only)
module press_decoder
    import press_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  logic       CLK,
    input  logic       ACLR_L,
    input  logic       PULSE,
    output logic       SINGLE,
    output logic       DOUBLE,
    output logic       TRIPLE,
    output logic       PENDING,
    output logic [1:0] LAST
);

    localparam int TW = $clog2(WINDOW + 1);

    state_t state_q;
    ev_t    last_q;
    logic   single_q;
    logic   double_q;
    logic   pending_q;
    logic   load;
    logic   dec;
    logic   expire;

    // A press always beats the timeout, so the timer only counts on press-free cycles.
    assign dec = (state_q != IDLE) && !PULSE;
`ifdef PRESS_TRIPLE_EN
    assign load = PULSE && ((state_q == IDLE) || (state_q == WAIT1));
`else
    assign load = PULSE && (state_q == IDLE);
`endif

    press_window_timer #(
        .WINDOW (WINDOW),
        .TW     (TW)
    ) u_timer (
        .CLK    (CLK),
        .ACLR_L (ACLR_L),
        .load   (load),
        .dec    (dec),
        .expire (expire)
    );

`ifdef PRESS_TRIPLE_EN
    logic triple_q;

    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            state_q   <= IDLE;
            last_q    <= EV_NONE;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            triple_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (PULSE) begin
                        state_q   <= WAIT1;
                        pending_q <= 1'b1;
                    end
                end
                WAIT1: begin
                    if (PULSE) begin
                        state_q <= WAIT2;
                    end else if (expire) begin
                        single_q  <= 1'b1;
                        last_q    <= EV_SINGLE;
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end
                end
                WAIT2: begin
                    if (PULSE) begin
                        triple_q  <= 1'b1;
                        last_q    <= EV_TRIPLE;
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end else if (expire) begin
                        double_q  <= 1'b1;
                        last_q    <= EV_DOUBLE;
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign TRIPLE = triple_q;
`else
    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            state_q   <= IDLE;
            last_q    <= EV_NONE;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            single_q <= 1'b0;
            double_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (PULSE) begin
                        state_q   <= WAIT1;
                        pending_q <= 1'b1;
                    end
                end
                WAIT1: begin
                    if (PULSE) begin
                        double_q  <= 1'b1;
                        last_q    <= EV_DOUBLE;
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end else if (expire) begin
                        single_q  <= 1'b1;
                        last_q    <= EV_SINGLE;
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign TRIPLE = 1'b0;
`endif

    assign SINGLE  = single_q;
    assign DOUBLE  = double_q;
    assign PENDING = pending_q;
    assign LAST    = last_q;

endmodule
